// File: rtl/chacha20_stream_xor.sv
// rtl/chacha20_stream_xor.sv - ChaCha20 keystream XOR stage for a 32-bit word stream
//
// Purpose:
//   Sits downstream of a ChaCha20 block core. Holds key/nonce/counter, asks the
//   core for one 512-bit keystream block per 16 data words, buffers that block
//   and XORs each accepted input word with the next keystream word. The result
//   leaves through a 1-deep registered valid/ready output stage.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_load/cfg_key/
//   cfg_nonce/cfg_counter      configuration, latched only in IDLE or ERR
//   s_valid/s_ready/
//   s_data/s_last              input word stream (first byte in [31:24])
//   m_valid/m_ready/
//   m_data/m_last              output word stream (s_data ^ keystream)
//   core_start/core_done       one-cycle request / completion pulses to the core
//   core_key/core_nonce/
//   core_counter/core_state    core inputs (core_state tied to zero)
//   core_out_state             keystream block, word i = [511-32*i -: 32]
//   busy                       high outside IDLE and ERR
//   err_ctr_wrap               sticky block-counter exhaustion flag

`timescale 1ns/1ps

module chacha20_stream_xor #(
  parameter int DW             = 32,
  parameter bit ALLOW_CTR_WRAP = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_load,
  input  logic [255:0]  cfg_key,
  input  logic [95:0]   cfg_nonce,
  input  logic [31:0]   cfg_counter,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          core_start,
  input  logic          core_done,
  output logic [255:0]  core_key,
  output logic [95:0]   core_nonce,
  output logic [31:0]   core_counter,
  output logic [511:0]  core_state,
  input  logic [511:0]  core_out_state,
  output logic          busy,
  output logic          err_ctr_wrap
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STREAM = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            configured_q, configured_d;
  logic [255:0]    key_q, key_d;
  logic [95:0]     nonce_q, nonce_d;
  logic [31:0]     ctr_q, ctr_d;
  logic [511:0]    ks_buf_q, ks_buf_d;
  logic [3:0]      idx_q, idx_d;
  logic            m_valid_q, m_valid_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic            m_last_q, m_last_d;
  logic            core_start_q, core_start_d;
  logic            err_q, err_d;

  logic            stream_rdy;
  logic            accept;
  logic [DW-1:0]   ks_word;

  always_comb begin
    state_d      = state_q;
    configured_d = configured_q;
    key_d        = key_q;
    nonce_d      = nonce_q;
    ctr_d        = ctr_q;
    ks_buf_d     = ks_buf_q;
    idx_d        = idx_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    core_start_d = 1'b0;
    err_d        = err_q;

    // Word 0 of the block sits in the top 32 bits, so idx counts down from the MSB.
    ks_word    = ks_buf_q[{4'd15 - idx_q, 5'd0} +: DW];
    stream_rdy = (state_q == ST_STREAM) && (!m_valid_q || m_ready);
    accept     = stream_rdy && s_valid;

    // Output register: loads on accept, otherwise empties once taken downstream.
    // This runs in every state so a pending word still drains after ERR/IDLE.
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data ^ ks_word;
      m_last_d  = s_last;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_load) begin
          key_d        = cfg_key;
          nonce_d      = cfg_nonce;
          ctr_d        = cfg_counter;
          configured_d = 1'b1;
        end
        // The pending word is left on the input; it is consumed in STREAM.
        if (s_valid && configured_q) begin
          state_d      = ST_REQ;
          core_start_d = 1'b1;
        end
      end

      ST_REQ: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (core_done) begin
          ks_buf_d = core_out_state;
          idx_d    = 4'd0;
          state_d  = ST_STREAM;
        end
      end

      ST_STREAM: begin
        if (accept) begin
          idx_d = idx_q + 4'd1;
          // Either end of message or end of block consumes this counter value.
          if (s_last || (idx_q == 4'd15)) begin
            if ((ctr_q == 32'hFFFF_FFFF) && !ALLOW_CTR_WRAP) begin
              err_d   = 1'b1;
              state_d = ST_ERR;
            end else begin
              ctr_d = ctr_q + 32'd1;
              if (s_last) begin
                state_d = ST_IDLE;
              end else begin
                state_d      = ST_REQ;
                core_start_d = 1'b1;
              end
            end
          end
        end
      end

      ST_ERR: begin
        if (cfg_load) begin
          key_d        = cfg_key;
          nonce_d      = cfg_nonce;
          ctr_d        = cfg_counter;
          configured_d = 1'b1;
          err_d        = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      configured_q <= 1'b0;
      key_q        <= '0;
      nonce_q      <= '0;
      ctr_q        <= '0;
      ks_buf_q     <= '0;
      idx_q        <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      core_start_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      configured_q <= configured_d;
      key_q        <= key_d;
      nonce_q      <= nonce_d;
      ctr_q        <= ctr_d;
      ks_buf_q     <= ks_buf_d;
      idx_q        <= idx_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      core_start_q <= core_start_d;
      err_q        <= err_d;
    end
  end

  assign s_ready      = stream_rdy;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_last       = m_last_q;
  assign core_start   = core_start_q;
  assign core_key     = key_q;
  assign core_nonce   = nonce_q;
  assign core_counter = ctr_q;
  assign core_state   = '0;
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_ERR);
  assign err_ctr_wrap = err_q;

endmodule

// File: tb/tb_chacha20_stream_xor.sv
// tb/tb_chacha20_stream_xor.sv - randomized scoreboard bench for chacha20_stream_xor

`timescale 1ns/1ps

module tb_chacha20_stream_xor;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_load;
  logic [255:0]  cfg_key;
  logic [95:0]   cfg_nonce;
  logic [31:0]   cfg_counter;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [31:0]   m_data;
  logic          m_last;
  logic          core_start;
  logic          core_done;
  logic [255:0]  core_key;
  logic [95:0]   core_nonce;
  logic [31:0]   core_counter;
  logic [511:0]  core_state;
  logic [511:0]  core_out_state;
  logic          busy;
  logic          err_ctr_wrap;

  always #5 clk = ~clk;

  chacha20_stream_xor dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_nonce(cfg_nonce), .cfg_counter(cfg_counter),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .core_start(core_start), .core_done(core_done), .core_key(core_key),
    .core_nonce(core_nonce), .core_counter(core_counter), .core_state(core_state),
    .core_out_state(core_out_state), .busy(busy), .err_ctr_wrap(err_ctr_wrap)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- ChaCha20 reference (RFC 8439 block function) ----------------
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // Key/nonce are byte strings with byte 0 in the MSBs; result is the serialized
  // 64-byte block with byte 0 in bits [511:504].
  function automatic logic [511:0] chacha_block(input logic [255:0] kk, input logic [31:0] cc,
                                                input logic [95:0] nn);
    logic [31:0] s[16];
    logic [31:0] x[16];
    logic [511:0] r;
    int qa[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int qb[8] = '{4, 5, 6, 7, 5, 6, 7, 4};
    int qc[8] = '{8, 9, 10, 11, 10, 11, 8, 9};
    int qd[8] = '{12, 13, 14, 15, 15, 12, 13, 14};
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = bswap(kk[255-32*i -: 32]);
    s[12] = cc;
    for (int i = 0; i < 3; i++) s[13+i] = bswap(nn[95-32*i -: 32]);
    x = s;
    for (int rnd = 0; rnd < 10; rnd++) begin
      for (int q = 0; q < 8; q++) begin
        int ia, ib, ic, id;
        ia = qa[q]; ib = qb[q]; ic = qc[q]; id = qd[q];
        x[ia] = x[ia] + x[ib]; x[id] = rotl(x[id] ^ x[ia], 16);
        x[ic] = x[ic] + x[id]; x[ib] = rotl(x[ib] ^ x[ic], 12);
        x[ia] = x[ia] + x[ib]; x[id] = rotl(x[id] ^ x[ia], 8);
        x[ic] = x[ic] + x[id]; x[ib] = rotl(x[ib] ^ x[ic], 7);
      end
    end
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = bswap(x[i] + s[i]);
    return r;
  endfunction

  // ---------------- behavioural stream model ----------------
  logic [255:0] mdl_key;
  logic [95:0]  mdl_nonce;
  logic [31:0]  mdl_ctr;
  int           mdl_pos;
  bit           mdl_err;
  bit           cache_ok;
  logic [31:0]  cache_ctr;
  logic [511:0] cache_blk;

  function automatic logic [31:0] ks_word(input logic [31:0] c, input int p);
    if (!cache_ok || cache_ctr != c) begin
      cache_blk = chacha_block(mdl_key, c, mdl_nonce);
      cache_ctr = c;
      cache_ok  = 1'b1;
    end
    return cache_blk[511-32*p -: 32];
  endfunction

  logic [32:0]  sb[$];
  logic [31:0]  out_log[$];
  logic [31:0]  start_ctrs[$];
  int           acc_cnt = 0;
  int           n_starts = 0;
  bit           mr_hold = 1'b0;
  bit           mr_rand = 1'b0;

  // Compare process: model every accepted input, check every delivered output.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (s_valid && s_ready) begin
        acc_cnt++;
        if (mdl_err) begin
          chk("no_accept_after_wrap_err", s_ready, 1'b0);
        end else begin
          sb.push_back({s_last, s_data ^ ks_word(mdl_ctr, mdl_pos)});
          mdl_pos++;
          if (s_last || mdl_pos == 16) begin
            mdl_pos = 0;
            if (mdl_ctr == 32'hFFFF_FFFF) mdl_err = 1'b1;
            else mdl_ctr = mdl_ctr + 32'd1;
          end
        end
      end
      if (m_valid && m_ready) begin
        out_log.push_back(m_data);
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL spurious_output: actual %h required none", m_data);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          chk("m_data", m_data, e[31:0]);
          chk("m_last", m_last, e[32]);
        end
      end
    end
  end

  // Core stand-in: random latency, result from the reference block function.
  initial begin
    core_done      = 1'b0;
    core_out_state = '0;
    forever begin
      @(negedge clk);
      if (rst_n && core_start) begin
        int  lat;
        bit  aborted;
        n_starts++;
        start_ctrs.push_back(core_counter);
        lat = $urandom_range(1, 6);
        aborted = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
          else if (!aborted) chk("s_ready_low_between_blocks", s_ready, 1'b0);
        end
        if (!aborted) begin
          core_out_state = chacha_block(core_key, core_counter, core_nonce);
          core_done = 1'b1;
          @(negedge clk);
          chk("core_counter_stable", core_counter, start_ctrs[$]);
          core_done = 1'b0;
        end
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = mr_hold ? 1'b0 : (mr_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    bit ok;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("send_word_accept");
    step();
    s_valid = 1'b0;
  endtask

  task automatic send_msg(input int n, input bit last_on_end, input bit zero, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
      send_word(zero ? 32'd0 : 32'($urandom), last_on_end && (i == n - 1));
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("drain");
    step();
  endtask

  task automatic do_cfg(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    cfg_key     = k;
    cfg_nonce   = n;
    cfg_counter = c;
    cfg_load    = 1'b1;
    step();
    cfg_load  = 1'b0;
    mdl_key   = k;
    mdl_nonce = n;
    mdl_ctr   = c;
    mdl_pos   = 0;
    mdl_err   = 1'b0;
    cache_ok  = 1'b0;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_s_ready"}, s_ready, 1'b0);
    chk({tag, "_m_valid"}, m_valid, 1'b0);
    chk({tag, "_m_data"}, m_data, 32'd0);
    chk({tag, "_m_last"}, m_last, 1'b0);
    chk({tag, "_core_start"}, core_start, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err_ctr_wrap, 1'b0);
    chk({tag, "_core_counter"}, core_counter, 32'd0);
    chk({tag, "_core_key"}, core_key, 256'd0);
  endtask

  task automatic bp_check(input int base);
    bit ok;
    logic [31:0] d;
    logic        l;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (acc_cnt >= base + 6) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_now("bp_reach_mid_block");
    end else begin
      mr_hold = 1'b1;
      @(negedge clk);
      chk("bp_m_valid_held", m_valid, 1'b1);
      d = m_data;
      l = m_last;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("bp_s_ready_low", s_ready, 1'b0);
        chk("bp_m_valid", m_valid, 1'b1);
        chk("bp_m_data_stable", m_data, d);
        chk("bp_m_last_stable", m_last, l);
      end
      mr_hold = 1'b0;
    end
  endtask

  // ---------------- test sequence ----------------
  localparam logic [255:0] RFC_KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [95:0]  RFC_NONCE = 96'h000000090000004a00000000;

  initial begin
    logic [31:0] c6;
    int base;
    rst_n = 1'b0; cfg_load = 1'b0; cfg_key = '0; cfg_nonce = '0; cfg_counter = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    mdl_key = '0; mdl_nonce = '0; mdl_ctr = '0; mdl_pos = 0; mdl_err = 1'b0; cache_ok = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    step();
    rst_n = 1'b1;
    step();

    // RFC 8439 block, 16 zero words, single block, s_last on word 15.
    do_cfg(RFC_KEY, RFC_NONCE, 32'd1);
    n_starts = 0; start_ctrs.delete(); out_log.delete();
    send_msg(16, 1'b1, 1'b1, 1'b0);
    drain();
    chk("rfc_word0", out_log[0], 32'h10f1e7e4);
    chk("rfc_word1", out_log[1], 32'hd13b5915);
    chk("rfc_word2", out_log[2], 32'h500fdd1f);
    chk("rfc_out_count", out_log.size(), 16);
    chk("rfc_one_start", n_starts, 1);
    chk("rfc_counter_after", core_counter, 32'd2);
    chk("rfc_idle", busy, 1'b0);

    // Same config, 20 zero words: crosses into a second block at counter 2.
    do_cfg(RFC_KEY, RFC_NONCE, 32'd1);
    n_starts = 0; start_ctrs.delete(); out_log.delete();
    send_msg(20, 1'b1, 1'b1, 1'b0);
    drain();
    chk("two_block_starts", n_starts, 2);
    chk("second_start_counter", start_ctrs[1], 32'd2);
    chk("word16_is_ctr2_word0", out_log[16], ks_word(32'd2, 0));
    chk("word19_is_ctr2_word3", out_log[19], ks_word(32'd2, 3));
    chk("two_block_counter_after", core_counter, 32'd3);

    // Random traffic with random downstream stalls and input gaps.
    mr_rand = 1'b1;
    do_cfg(rand256(), 96'({$urandom, $urandom, $urandom}), 32'($urandom) & 32'h7fff_ffff);
    send_msg(40, 1'b1, 1'b0, 1'b1);
    drain();

    // Explicit 5-cycle stall mid-block.
    mr_rand = 1'b0;
    do_cfg(rand256(), 96'({$urandom, $urandom, $urandom}), 32'($urandom) & 32'h7fff_ffff);
    base = acc_cnt;
    fork
      send_msg(14, 1'b1, 1'b0, 1'b0);
      bp_check(base);
    join
    drain();

    // Short message then a second message on the next counter.
    mr_rand = 1'b1;
    do_cfg(rand256(), 96'({$urandom, $urandom, $urandom}), 32'($urandom) & 32'h7fff_ffff);
    send_msg(4, 1'b1, 1'b0, 1'b1);
    drain();
    chk("short_idle", busy, 1'b0);
    chk("short_counter", core_counter, mdl_ctr);
    send_msg(3, 1'b1, 1'b0, 1'b1);
    drain();

    // Counter exhaustion with wrap disabled.
    do_cfg(rand256(), 96'({$urandom, $urandom, $urandom}), 32'hFFFF_FFFF);
    out_log.delete();
    send_msg(16, 1'b0, 1'b0, 1'b1);
    drain();
    chk("wrap_all_outputs", out_log.size(), 16);
    chk("wrap_err_set", err_ctr_wrap, 1'b1);
    chk("wrap_not_busy", busy, 1'b0);
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("wrap_s_ready_low", s_ready, 1'b0);
    end
    step();
    s_valid = 1'b0;
    do_cfg(rand256(), 96'({$urandom, $urandom, $urandom}), 32'd5);
    @(negedge clk);
    chk("wrap_err_cleared", err_ctr_wrap, 1'b0);
    step();
    send_msg(2, 1'b1, 1'b0, 1'b1);
    drain();

    // cfg_load during STREAM is ignored; then reset mid-STREAM.
    mr_rand = 1'b0;
    c6 = 32'($urandom) & 32'h7fff_ffff;
    do_cfg(rand256(), 96'({$urandom, $urandom, $urandom}), c6);
    send_msg(3, 1'b0, 1'b0, 1'b0);
    cfg_key = rand256(); cfg_counter = c6 + 32'd77; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    @(negedge clk);
    chk("ignored_cfg_counter", core_counter, c6);
    chk("ignored_cfg_key", core_key, mdl_key);
    step();
    send_msg(2, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    check_reset_outputs("midstream_reset");
    step();
    rst_n = 1'b1;
    n_starts = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("unconfigured_not_busy", busy, 1'b0);
    end
    chk("unconfigured_no_start", n_starts, 0);
    step();
    s_valid = 1'b0;
    do_cfg(rand256(), 96'({$urandom, $urandom, $urandom}), 32'($urandom) & 32'h7fff_ffff);
    mr_rand = 1'b1;
    send_msg(5, 1'b1, 1'b0, 1'b1);
    drain();

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
